// File: rtl/analog_spinner.sv
// Spinner angle generator for MCR2 dial inputs: converts analog stick X or
// left/right buttons into an 8-bit wrapping angle, updated once per video frame.
module analog_spinner #(
  parameter int unsigned DEADZONE = 8,
  parameter int unsigned SHIFT    = 4,
  parameter int unsigned MAX_STEP = 15
) (
  input  logic       clock_40,
  input  logic       reset_n,
  input  logic       vsync,
  input  logic [7:0] analog_x,
  input  logic       use_analog,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic [7:0] spin_angle,
  output logic       step_valid
);

  localparam int unsigned SUM_W  = 9;
  localparam int unsigned HOLD_W = 5;
  localparam int unsigned MAG_W  = 7;

  typedef enum logic [1:0] {
    WAIT_VS = 2'd0,
    CALC    = 2'd1,
    APPLY   = 2'd2
  } state_e;

  state_e              state_q;
  logic                vs_meta_q, vs_sync_q, vs_dly_q;
  logic [7:0]          angle_q;
  logic                valid_q;
  logic [7:0]          step_q;
  logic [SHIFT-1:0]    frac_q;
  logic [HOLD_W-1:0]   hold_q;
  logic                dir_q;

  logic                vs_edge_c;
  logic [7:0]          mag_c;
  logic                analog_sel_c;
  logic                one_btn_c;
  logic [SUM_W-1:0]    sum_c;
  logic [SUM_W-1:0]    amag_c;
  logic [HOLD_W-1:0]   hold_eff_c;
  logic [3:0]          bmag_c;
  logic [MAG_W-1:0]    step_mag_c;
  logic                step_neg_c;
  logic [7:0]          step_d;
  logic [SHIFT-1:0]    frac_d;
  logic [HOLD_W-1:0]   hold_d;
  logic                dir_d;

  // Flops reset high so a vsync already high at reset release is not an edge.
  assign vs_edge_c = vs_sync_q & ~vs_dly_q;

  assign mag_c        = analog_x[7] ? 8'(~analog_x + 8'd1) : analog_x;
  assign analog_sel_c = use_analog && (mag_c > 8'(DEADZONE));
  assign one_btn_c    = btn_left ^ btn_right;
  assign sum_c        = SUM_W'(mag_c) - SUM_W'(DEADZONE) + SUM_W'(frac_q);
  assign amag_c       = sum_c >> SHIFT;
  // A direction change restarts acceleration from zero.
  assign hold_eff_c   = ((hold_q != '0) && (dir_q != btn_right)) ? '0 : hold_q;
  assign bmag_c       = 4'd1 + {1'b0, hold_eff_c[4:2]};

  always_comb begin
    step_mag_c = '0;
    step_neg_c = 1'b0;
    frac_d     = '0;
    hold_d     = '0;
    dir_d      = dir_q;
    if (analog_sel_c) begin
      step_neg_c = analog_x[7];
      if (amag_c > SUM_W'(MAX_STEP)) begin
        step_mag_c = MAG_W'(MAX_STEP);
      end else begin
        step_mag_c = MAG_W'(amag_c);
        frac_d     = sum_c[SHIFT-1:0];
      end
    end else if (one_btn_c) begin
      step_neg_c = btn_left;
      dir_d      = btn_right;
      if (SUM_W'(bmag_c) > SUM_W'(MAX_STEP)) begin
        step_mag_c = MAG_W'(MAX_STEP);
      end else begin
        step_mag_c = MAG_W'(bmag_c);
      end
      hold_d = (hold_eff_c == 5'd31) ? 5'd31 : hold_eff_c + 5'd1;
    end
    step_d = step_neg_c ? 8'(~{1'b0, step_mag_c}) + 8'd1 : {1'b0, step_mag_c};
  end

  always_ff @(posedge clock_40 or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= WAIT_VS;
      vs_meta_q <= 1'b1;
      vs_sync_q <= 1'b1;
      vs_dly_q  <= 1'b1;
      angle_q   <= '0;
      valid_q   <= 1'b0;
      step_q    <= '0;
      frac_q    <= '0;
      hold_q    <= '0;
      dir_q     <= 1'b0;
    end else begin
      vs_meta_q <= vsync;
      vs_sync_q <= vs_meta_q;
      vs_dly_q  <= vs_sync_q;
      valid_q   <= 1'b0;
      case (state_q)
        WAIT_VS: if (vs_edge_c) state_q <= CALC;
        CALC: begin
          step_q  <= step_d;
          frac_q  <= frac_d;
          hold_q  <= hold_d;
          dir_q   <= dir_d;
          state_q <= APPLY;
        end
        APPLY: begin
          angle_q <= angle_q + step_q;
          valid_q <= 1'b1;
          state_q <= WAIT_VS;
        end
        default: state_q <= WAIT_VS;
      endcase
    end
  end

  assign spin_angle = angle_q;
  assign step_valid = valid_q;

endmodule
